// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: takes 64-bit frames from the SPI slave word port and runs them as
// register-bus commands (NOP / write / read). It then builds the response word that the
// host shifts out during its next transaction.
// Ports:
//   clk_i, rst_i                 system clock, synchronous active-high reset
//   data_in_i, data_ready_i      frame and frame-valid pulse from the slave (sclk domain)
//   data_out_o                   response word {status, addr, seq, data}
//   wr_en_o/wr_addr_o/wr_data_o  one-cycle register write strobe
//   rd_req_o/rd_addr_o           read request, held until rd_ack_i or timeout
//   rd_ack_i/rd_data_i           read completion
//   frame_count_o, err_count_o, overrun_count_o  status counters
module spi_cmd_decoder #(
  parameter int unsigned data_length = 64,
  parameter int unsigned rd_timeout  = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [data_length-1:0] data_in_i,
  input  logic                   data_ready_i,
  output logic [data_length-1:0] data_out_o,
  output logic                   wr_en_o,
  output logic [7:0]             wr_addr_o,
  output logic [31:0]            wr_data_o,
  output logic                   rd_req_o,
  output logic [7:0]             rd_addr_o,
  input  logic                   rd_ack_i,
  input  logic [31:0]            rd_data_i,
  output logic [15:0]            frame_count_o,
  output logic [7:0]             err_count_o,
  output logic [7:0]             overrun_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WRITE, S_READ, S_RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(rd_timeout - 1);

  state_t                 state_q, state_d;
  logic                   s1_q, s2_q, s3_q;
  logic [data_length-1:0] frame_q, frame_d;
  logic [7:0]             status_q, status_d;
  logic [31:0]            resp_q, resp_d;
  logic [7:0]             timer_q, timer_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [7:0]             ovr_cnt_q, ovr_cnt_d;
  logic [data_length-1:0] data_out_q, data_out_d;
  logic                   wr_en_q, wr_en_d;
  logic [7:0]             wr_addr_q, wr_addr_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic                   rd_req_q, rd_req_d;
  logic [7:0]             rd_addr_q, rd_addr_d;

  // Rising edge of the synchronised frame-valid pulse; high for exactly one cycle.
  logic ready_edge;
  assign ready_edge = s2_q & ~s3_q;

  logic [7:0]  f_opcode;
  logic [7:0]  f_addr;
  logic [15:0] f_seq;
  logic [31:0] f_payload;
  assign f_opcode  = frame_q[63:56];
  assign f_addr    = frame_q[55:48];
  assign f_seq     = frame_q[47:32];
  assign f_payload = frame_q[31:0];

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    status_d    = status_q;
    resp_d      = resp_q;
    timer_d     = timer_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    data_out_d  = data_out_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;

    // A frame arriving while a command is in flight is dropped, not queued.
    if (ready_edge && (state_q != S_IDLE) && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (ready_edge) begin
          frame_d     = data_in_i;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        // wr_en/rd_req are registered, so they are set on entry to WRITE/READ.
        case (f_opcode)
          8'h01: begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = f_addr;
            wr_data_d = f_payload;
            status_d  = 8'h00;
            resp_d    = f_payload;
          end
          8'h02: begin
            state_d   = S_READ;
            timer_d   = 8'd0;
            rd_req_d  = 1'b1;
            rd_addr_d = f_addr;
          end
          8'h00: begin
            state_d  = S_RESP;
            status_d = 8'h02;
            resp_d   = {16'h0, frame_cnt_q};
          end
          default: begin
            state_d  = S_RESP;
            status_d = 8'h80;
            resp_d   = 32'h0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        endcase
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_READ: begin
        // Ack wins over a timeout landing in the same cycle.
        if (rd_ack_i) begin
          resp_d   = rd_data_i;
          status_d = 8'h01;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          resp_d   = 32'h0;
          status_d = 8'h81;
          state_d  = S_RESP;
        end else begin
          timer_d  = timer_q + 8'd1;
          rd_req_d = 1'b1;
        end
      end
      S_RESP: begin
        data_out_d = {status_q, f_addr, f_seq, resp_q};
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      frame_q     <= '0;
      status_q    <= 8'h0;
      resp_q      <= 32'h0;
      timer_q     <= 8'h0;
      frame_cnt_q <= 16'h0;
      err_cnt_q   <= 8'h0;
      ovr_cnt_q   <= 8'h0;
      data_out_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h0;
      wr_data_q   <= 32'h0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= 8'h0;
    end else begin
      state_q     <= state_d;
      s1_q        <= data_ready_i;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      frame_q     <= frame_d;
      status_q    <= status_d;
      resp_q      <= resp_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      data_out_q  <= data_out_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign data_out_o      = data_out_q;
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign rd_req_o        = rd_req_q;
  assign rd_addr_o       = rd_addr_q;
  assign frame_count_o   = frame_cnt_q;
  assign err_count_o     = err_cnt_q;
  assign overrun_count_o = ovr_cnt_q;

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Downstream consumer of the SPI slave word port. Synchronises the slave's `data_ready` pulse into the system clock domain and captures the 64-bit `data_in` frame. It decodes the frame as a register-bus command (NOP / write / read) and drives a simple register write strobe and read request/acknowledge handshake. It then builds the 64-bit response word presented on the slave's `data_out`, which the host shifts out during the next transaction.

## Interface
- `data_length`, 64: SPI frame width; must be 64, since the frame layout below is fixed.
- `rd_timeout`, 255: maximum cycles in READ waiting for `rd_ack`; range 1..255.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  data_length  frame from SPI slave (sclk domain; stable for a full frame after `data_ready`).
- `data_ready`  in  1  SPI slave frame-valid pulse (sclk domain, one sclk period wide).
- `data_out`  out  data_length  response word to SPI slave.
- `wr_en`  out  1  register write strobe, one cycle.
- `wr_addr`  out  8  write address.
- `wr_data`  out  32  write data.
- `rd_req`  out  1  read request, held until ack or timeout.
- `rd_addr`  out  8  read address.
- `rd_ack`  in  1  read data valid.
- `rd_data`  in  32  read data, sampled when `rd_ack`=1.
- `frame_count`  out  16  frames accepted, wraps at 0xFFFF→0.
- `err_count`  out  8  bad-opcode frames, saturates at 0xFF.
- `overrun_count`  out  8  frames dropped while busy, saturates at 0xFF.

## Operation
- Frame layout: [63:56] opcode, [55:48] addr, [47:32] seq, [31:0] payload.
- Sync: `data_ready` passes through 2 flops (s1, s2) plus a history flop s3. The event is `edge` = s2 & ~s3. `data_in` is not synchronised; it is stable because it is held until the next frame completes.
- Constraint: f_clk ≥ 3× f_sclk, so the pulse is never missed.
- FSM states: IDLE, DECODE, WRITE, READ, RESP.
- IDLE: on `edge`, frame register ← `data_in`, `frame_count`++, go to DECODE.
- DECODE: transition depends on opcode.
  - Opcode 0x01 → WRITE.
  - Opcode 0x02 → READ (timer cleared).
  - Opcode 0x00 → RESP with status 0x02, data = {16'h0, `frame_count`}.
  - Any other opcode → RESP with status 0x80, data 0, `err_count`++.
- WRITE: `wr_en`=1 for exactly this cycle, `wr_addr`=addr, `wr_data`=payload; status 0x00, data = payload; go to RESP.
- READ: `rd_req`=1, `rd_addr`=addr.
  - If `rd_ack`: capture `rd_data`, status 0x01, go to RESP.
  - Else if timer = `rd_timeout`-1: status 0x81, data 0, go to RESP.
  - Otherwise timer++.
  - `rd_ack` arriving in the same cycle the timeout expires counts as success.
- RESP: `data_out` ← {status[7:0], addr[7:0], seq[15:0], data[31:0]}, go to IDLE.
- `edge` in any state other than IDLE: frame is dropped, `overrun_count`++, FSM unaffected, `frame_count` unchanged.
- `rd_ack` outside READ is ignored.
- `data_out` holds its value until the next RESP.

## Timing
- Reset values:
  - FSM = IDLE, sync flops = 0.
  - `data_out` = 0, `wr_en` = 0, `rd_req` = 0.
  - `wr_addr`/`wr_data`/`rd_addr` = 0.
  - All counters = 0.
- Reset mid-operation aborts the frame. No further `wr_en` or `rd_req` is issued. A pending `edge` is lost.
- `data_ready` rise is sampled into s1 at cycle 0; `edge` is high in cycle 2.
- Let E be the `edge` cycle. DECODE is at E+1.
- Write: `wr_en` high in E+2, RESP in E+3, new `data_out` visible from E+4.
- Read: `rd_req` high from E+2. If ack is in cycle A, `rd_req` drops at A+1 (RESP) and `data_out` updates at A+2.
- Read timeout: `rd_req` is high for exactly `rd_timeout` cycles.
- NOP / bad opcode: RESP in E+2, `data_out` from E+3.
- `wr_en`, `rd_req` and `data_out` are registered; no combinational path from inputs to outputs.
- The host must leave enough time between frames for the response to be loaded before the slave reloads its shift register.

## Test plan
- Reset, then frame 0x01_10_0007_DEADBEEF → `wr_en` single pulse with `wr_addr`=0x10, `wr_data`=0xDEADBEEF; `data_out`=0x00_10_0007_DEADBEEF; `frame_count`=1.
- Frame 0x02_22_0001_00000000, `rd_ack` asserted 5 cycles after `rd_req` with `rd_data`=0x12345678 → `data_out`=0x01_22_0001_12345678, `rd_req` drops the cycle after ack.
- Read with `rd_ack` never asserted, `rd_timeout`=4 → `rd_req` high exactly 4 cycles; `data_out`=0x81_22_0001_00000000.
- Opcode 0x7F frame → `data_out`=0x80_addr_seq_00000000 and `err_count`=1. Also 300 bad frames → `err_count` saturates at 0xFF.
- Second `data_ready` pulse while in READ → `overrun_count`=1, the read completes normally, `frame_count` unchanged by the dropped frame. Then a NOP → `data_out` data field = current `frame_count`.
- `rst` asserted in READ → `rd_req`=0 the next cycle, `data_out`=0, all counters 0, FSM in IDLE; the next frame is processed normally.
